// File: rtl/mem_stage_sized_if.sv
// Upstream request and registered writeback-facing result of the sized MEM stage.
// master drives requests and the stall; slave is the stage itself.
interface mem_stage_sized_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int REG_IDX_WIDTH  = 6
);
  logic                      in_valid;
  logic                      stall;
  logic [REG_IDX_WIDTH-1:0]  inWriteRegister;
  logic [BUS_DATA_WIDTH-1:0] addressOrAluData;
  logic [BUS_DATA_WIDTH-1:0] writeData;
  logic                      inMemOrReg;
  logic                      memRead;
  logic                      memWrite;
  logic [1:0]                accessSize;
  logic                      loadUnsigned;

  logic                      out_valid;
  logic [BUS_DATA_WIDTH-1:0] readData;
  logic [BUS_DATA_WIDTH-1:0] outAluData;
  logic [REG_IDX_WIDTH-1:0]  outWriteRegister;
  logic                      outMemOrReg;
  logic                      misaligned;

  modport master (
    output in_valid, stall, inWriteRegister, addressOrAluData, writeData,
           inMemOrReg, memRead, memWrite, accessSize, loadUnsigned,
    input  out_valid, readData, outAluData, outWriteRegister, outMemOrReg, misaligned
  );

  modport slave (
    input  in_valid, stall, inWriteRegister, addressOrAluData, writeData,
           inMemOrReg, memRead, memWrite, accessSize, loadUnsigned,
    output out_valid, readData, outAluData, outWriteRegister, outMemOrReg, misaligned
  );
endinterface

// File: rtl/mem_stage_sized.sv
// Sized MEM stage: local byte-lane RAM, extended loads, misalignment flag; 1-cycle registered output.
// Under stall every output holds and the RAM is not written; reset clears outputs only.
module mem_stage_sized #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DEPTH_LOG2     = 10,
  parameter int REG_IDX_WIDTH  = 6
) (
  input logic              clk,
  input logic              reset,
  mem_stage_sized_if.slave bus
);
  localparam int NumBytes = BUS_DATA_WIDTH / 8;
  localparam int OffWidth = $clog2(NumBytes);
  localparam int Depth    = 1 << DEPTH_LOG2;

  typedef logic [BUS_DATA_WIDTH-1:0] word_t;

  word_t ram [Depth];

  logic [OffWidth-1:0]   off;
  logic [DEPTH_LOG2-1:0] wordIdx;
  logic [OffWidth-1:0]   alignMask;
  logic [NumBytes-1:0]   laneSize;
  logic [NumBytes-1:0]   byteEn;
  logic                  sizeLegal;
  logic                  aligned;
  logic                  accept;
  logic                  isOp;
  logic                  isLoad;
  logic                  isStore;
  logic                  misalignedOp;
  logic                  doWrite;
  logic                  signBit;
  word_t                 lowMask;
  word_t                 wrShifted;
  word_t                 rdWord;
  word_t                 rdShifted;
  word_t                 loadResult;

  logic                     outValidQ;
  word_t                    readDataQ;
  word_t                    outAluDataQ;
  logic [REG_IDX_WIDTH-1:0] outWriteRegisterQ;
  logic                     outMemOrRegQ;
  logic                     misalignedQ;

  // Upper address bits beyond the word index are dropped, so accesses wrap.
  assign off     = bus.addressOrAluData[OffWidth-1:0];
  assign wordIdx = bus.addressOrAluData[OffWidth +: DEPTH_LOG2];

  always_comb begin
    alignMask = '0;
    laneSize  = '0;
    sizeLegal = 1'b1;
    case (bus.accessSize)
      2'd0: begin
        alignMask = OffWidth'(0);
        laneSize  = NumBytes'(8'h01);
      end
      2'd1: begin
        alignMask = OffWidth'(1);
        laneSize  = NumBytes'(8'h03);
      end
      2'd2: begin
        alignMask = OffWidth'(3);
        laneSize  = NumBytes'(8'h0F);
      end
      default: begin
        alignMask = OffWidth'(7);
        laneSize  = NumBytes'(8'hFF);
        sizeLegal = (NumBytes == 8);
      end
    endcase
  end

  // A simultaneous read and write request resolves to a load.
  assign accept       = bus.in_valid & ~bus.stall & ~reset;
  assign isOp         = accept & ~bus.inMemOrReg & (bus.memRead | bus.memWrite);
  assign isLoad       = isOp & bus.memRead;
  assign isStore      = isOp & ~bus.memRead & bus.memWrite;
  assign aligned      = sizeLegal & ((off & alignMask) == '0);
  assign misalignedOp = isOp & ~aligned;
  assign doWrite      = isStore & aligned;

  assign byteEn    = laneSize << off;
  assign wrShifted = bus.writeData << {off, 3'b000};

  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (byteEn[b]) ram[wordIdx][8*b +: 8] <= wrShifted[8*b +: 8];
      end
    end
  end

  // Asynchronous read so a load right after a store to the same word sees the new bytes.
  assign rdWord    = ram[wordIdx];
  assign rdShifted = rdWord >> {off, 3'b000};

  always_comb begin
    lowMask = '1;
    signBit = 1'b0;
    case (bus.accessSize)
      2'd0: begin
        lowMask = word_t'(8'hFF);
        signBit = rdShifted[7];
      end
      2'd1: begin
        lowMask = word_t'(16'hFFFF);
        signBit = rdShifted[15];
      end
      2'd2: begin
        lowMask = word_t'(32'hFFFF_FFFF);
        signBit = rdShifted[31];
      end
      default: begin
        lowMask = '1;
        signBit = 1'b0;
      end
    endcase
  end

  // A full-bus-width access has an all-ones mask, so it is never extended.
  assign loadResult = (rdShifted & lowMask)
                    | ({BUS_DATA_WIDTH{signBit & ~bus.loadUnsigned}} & ~lowMask);

  always_ff @(posedge clk) begin
    if (reset) begin
      outValidQ         <= 1'b0;
      readDataQ         <= '0;
      outAluDataQ       <= '0;
      outWriteRegisterQ <= '0;
      outMemOrRegQ      <= 1'b0;
      misalignedQ       <= 1'b0;
    end else if (!bus.stall) begin
      outValidQ   <= bus.in_valid;
      misalignedQ <= misalignedOp;
      if (bus.in_valid) begin
        outWriteRegisterQ <= bus.inWriteRegister;
        outMemOrRegQ      <= bus.inMemOrReg;
        if (misalignedOp) begin
          readDataQ <= '0;
        end else if (isLoad) begin
          readDataQ <= loadResult;
        end
        if (bus.inMemOrReg) outAluDataQ <= bus.addressOrAluData;
      end
    end
  end

  assign bus.out_valid        = outValidQ;
  assign bus.readData         = readDataQ;
  assign bus.outAluData       = outAluDataQ;
  assign bus.outWriteRegister = outWriteRegisterQ;
  assign bus.outMemOrReg      = outMemOrRegQ;
  assign bus.misaligned       = misalignedQ;
endmodule

// File: tb/tb_mem_stage_sized.sv
// Bench: a 64-bit and a 32-bit stage (16-word RAMs) share one stimulus stream and are
// compared every cycle against a byte-addressed memory model.
module tb_mem_stage_sized;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stage_sized_if #(.BUS_DATA_WIDTH(64), .REG_IDX_WIDTH(6)) b64 ();
  mem_stage_sized_if #(.BUS_DATA_WIDTH(32), .REG_IDX_WIDTH(6)) b32 ();

  mem_stage_sized #(.BUS_DATA_WIDTH(64), .DEPTH_LOG2(4), .REG_IDX_WIDTH(6)) u64 (
    .clk(clk), .reset(rst), .bus(b64)
  );
  mem_stage_sized #(.BUS_DATA_WIDTH(32), .DEPTH_LOG2(4), .REG_IDX_WIDTH(6)) u32 (
    .clk(clk), .reset(rst), .bus(b32)
  );

  typedef struct packed {
    logic        valid;
    logic [63:0] rdat;
    logic [63:0] alu;
    logic [5:0]  wreg;
    logic        mor;
    logic        mis;
  } exp_t;

  exp_t       e [2];
  logic [7:0] mem [2][128];

  logic        s_vld, s_stl, s_rst, s_mor, s_rd, s_wr, s_uns;
  logic [1:0]  s_sz;
  logic [5:0]  s_reg;
  logic [63:0] s_addr, s_wdat;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Memory semantics stated directly on bytes: little-endian, wrap modulo RAM size.
  task automatic model_edge(input int k);
    int nb;
    int msz;
    int size;
    int idx;
    logic isop, mis;
    logic [63:0] v, wmask;
    nb    = (k == 0) ? 8 : 4;
    msz   = nb * 16;
    wmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (s_rst) begin
      e[k] = '0;
    end else if (!s_stl) begin
      e[k].valid = s_vld;
      e[k].mis   = 1'b0;
      if (s_vld) begin
        e[k].wreg = s_reg;
        e[k].mor  = s_mor;
        size = 1 << s_sz;
        isop = !s_mor && (s_rd || s_wr);
        mis  = isop && ((size > nb) || ((s_addr % 64'(size)) != 0));
        e[k].mis = mis;
        if (s_mor) e[k].alu = s_addr & wmask;
        if (isop) begin
          if (mis) begin
            e[k].rdat = '0;
          end else if (s_rd) begin
            v = '0;
            for (int i = 0; i < size; i++) begin
              idx = int'((s_addr + 64'(i)) % 64'(msz));
              v = v | (64'(mem[k][idx]) << (8 * i));
            end
            if (!s_uns && size < nb && v[8*size-1]) v = v | (~64'd0 << (8 * size));
            e[k].rdat = v & wmask;
          end else begin
            for (int i = 0; i < size; i++) begin
              idx = int'((s_addr + 64'(i)) % 64'(msz));
              mem[k][idx] = 8'(s_wdat >> (8 * i));
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("v64",   64'(b64.out_valid),        64'(e[0].valid));
    chk("rd64",  b64.readData,              e[0].rdat);
    chk("alu64", b64.outAluData,            e[0].alu);
    chk("wr64",  64'(b64.outWriteRegister), 64'(e[0].wreg));
    chk("mor64", 64'(b64.outMemOrReg),      64'(e[0].mor));
    chk("mis64", 64'(b64.misaligned),       64'(e[0].mis));
    chk("v32",   64'(b32.out_valid),        64'(e[1].valid));
    chk("rd32",  64'(b32.readData),         e[1].rdat);
    chk("alu32", 64'(b32.outAluData),       e[1].alu);
    chk("wr32",  64'(b32.outWriteRegister), 64'(e[1].wreg));
    chk("mor32", 64'(b32.outMemOrReg),      64'(e[1].mor));
    chk("mis32", 64'(b32.misaligned),       64'(e[1].mis));
  endtask

  task automatic cyc(input logic vld, stl, rr, mor, rd, wr, input logic [1:0] sz,
                     input logic uns, input logic [63:0] addr, wdat);
    s_vld = vld; s_stl = stl; s_rst = rr; s_mor = mor; s_rd = rd; s_wr = wr;
    s_sz = sz; s_uns = uns; s_addr = addr; s_wdat = wdat; s_reg = 6'($urandom);
    rst = rr;
    b64.in_valid = vld; b64.stall = stl; b64.inWriteRegister = s_reg;
    b64.addressOrAluData = addr; b64.writeData = wdat; b64.inMemOrReg = mor;
    b64.memRead = rd; b64.memWrite = wr; b64.accessSize = sz; b64.loadUnsigned = uns;
    b32.in_valid = vld; b32.stall = stl; b32.inWriteRegister = s_reg;
    b32.addressOrAluData = addr[31:0]; b32.writeData = wdat[31:0]; b32.inMemOrReg = mor;
    b32.memRead = rd; b32.memWrite = wr; b32.accessSize = sz; b32.loadUnsigned = uns;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  task automatic st(input logic [1:0] sz, input logic [63:0] addr, wdat);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sz, 1'b0, addr, wdat);
  endtask

  task automatic ld(input logic [1:0] sz, input logic [63:0] addr, input logic uns);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sz, uns, addr, 64'd0);
  endtask

  logic [63:0] ra, rdat, held;
  logic [1:0]  rsz;
  int          kind;

  initial begin
    for (int k = 0; k < 2; k++) e[k] = '0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 64'h0, 64'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
    chk("reset_valid", 64'(b64.out_valid), 64'd0);
    chk("reset_rdata", b64.readData, 64'd0);

    // Give every RAM byte a known value in both stages.
    for (int a = 0; a < 128; a += 4) st(2'd2, 64'(a), {$urandom, $urandom});

    st(2'd3, 64'h10, 64'h1122_3344_5566_7788);
    ld(2'd0, 64'h13, 1'b0);
    chk("ld_byte_0x13", b64.readData, 64'h55);
    ld(2'd1, 64'h16, 1'b0);
    chk("ld_half_0x16", b64.readData, 64'h1122);

    st(2'd0, 64'h20, 64'hF0);
    ld(2'd0, 64'h20, 1'b0);
    chk("ld_byte_signed", b64.readData, 64'hFFFF_FFFF_FFFF_FFF0);
    ld(2'd0, 64'h20, 1'b1);
    chk("ld_byte_unsigned", b64.readData, 64'h0000_0000_0000_00F0);
    ld(2'd3, 64'h20, 1'b0);

    st(2'd2, 64'h22, 64'hAAAA_BBBB);
    chk("mis_store_flag", 64'(b64.misaligned), 64'd1);
    chk("mis_store_valid", 64'(b64.out_valid), 64'd1);
    ld(2'd3, 64'h20, 1'b0);
    ld(2'd1, 64'h21, 1'b0);
    chk("mis_load_flag", 64'(b64.misaligned), 64'd1);
    chk("mis_load_rdata", b64.readData, 64'd0);

    ld(2'd3, 64'h08, 1'b0);
    held = e[0].rdat;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 64'h30, 64'hCAFE_F00D_1234_5678);
      chk("stall_hold", b64.readData, held);
    end
    ld(2'd3, 64'h30, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 64'h30, 64'hCAFE_F00D_1234_5678);
    ld(2'd3, 64'h30, 1'b0);
    chk("stall_commit", b64.readData, 64'hCAFE_F00D_1234_5678);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
    chk("bubble_valid", 64'(b64.out_valid), 64'd0);

    st(2'd3, 64'h80, 64'h0102_0304_0506_0708);
    ld(2'd3, 64'h00, 1'b0);
    chk("wrap_load", b64.readData, 64'h0102_0304_0506_0708);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 64'h00, 64'hDEAD_DEAD_DEAD_DEAD);
    chk("rst_valid", 64'(b64.out_valid), 64'd0);
    chk("rst_rdata", b64.readData, 64'd0);
    ld(2'd3, 64'h00, 1'b0);
    chk("after_rst_ram", b64.readData, 64'h0102_0304_0506_0708);

    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 64'hDEAD, 64'h5555_5555_5555_5555);
    chk("alu_pass64", b64.outAluData, 64'hDEAD);
    chk("alu_pass32", 64'(b32.outAluData), 64'hDEAD);
    chk("alu_mis", 64'(b64.misaligned), 64'd0);
    ld(2'd3, 64'hDEA8, 1'b0);
    st(2'd3, 64'h40, 64'h7777_6666_5555_4444);
    chk("size3_on_32", 64'(b32.misaligned), 64'd1);

    for (int n = 0; n < 500; n++) begin
      ra = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) ra[63:32] = $urandom;
      rsz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0) ra = ra & ~64'((1 << rsz) - 1);
      rdat = {$urandom, $urandom};
      kind = $urandom_range(0, 19);
      if (kind == 0)
        cyc(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, rsz, 1'b0, ra, rdat);
      else if (kind <= 2)
        cyc(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), rsz, 1'b0, ra, rdat);
      else if (kind <= 4)
        cyc(1'($urandom), 1'b1, 1'b0, 1'b0, 1'($urandom), 1'b1, rsz, 1'b0, ra, rdat);
      else if (kind <= 7)
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), rsz, 1'b0, rdat, ra);
      else if (kind <= 12)
        st(rsz, ra, rdat);
      else if (kind <= 18)
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom), rsz, 1'($urandom), ra, rdat);
      else
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rsz, 1'b0, ra, rdat);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_stage_sized.md
Name: mem_stage_sized

Overview:
- Parametrised successor to the single-width pipeline MEM stage (stage 4).
- Holds a local word-organised data RAM and supports byte, half, word and double accesses with byte-lane writes and sign- or zero-extended loads.
- Detects misaligned accesses and has a valid/stall handshake, so the stage can hold under a downstream stall.
- Registers everything for the writeback stage (stage 5).

Parameters:
- BUS_DATA_WIDTH, 64, data path width in bits; must be 32 or 64.
- DEPTH_LOG2, 10, log2 of the RAM depth in BUS_DATA_WIDTH-wide words.
- REG_IDX_WIDTH, 6, width of the destination register index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  the upstream slot holds an instruction.
- stall  in  1  the downstream stage cannot accept; this stage holds.
- inWriteRegister  in  REG_IDX_WIDTH  destination register index.
- addressOrAluData  in  BUS_DATA_WIDTH  byte address for loads/stores; ALU result otherwise.
- writeData  in  BUS_DATA_WIDTH  store data, right-aligned.
- inMemOrReg  in  1  1 = ALU result passes through; 0 = memory op.
- memRead  in  1  load.
- memWrite  in  1  store.
- accessSize  in  2  0 = byte, 1 = half, 2 = word, 3 = double. Value 3 is illegal when BUS_DATA_WIDTH = 32.
- loadUnsigned  in  1  1 = zero-extend, 0 = sign-extend.
- out_valid  out  1  the output slot holds an instruction.
- readData  out  BUS_DATA_WIDTH  extended load result.
- outAluData  out  BUS_DATA_WIDTH  passed-through ALU result.
- outWriteRegister  out  REG_IDX_WIDTH  passed-through destination index.
- outMemOrReg  out  1  passed-through select.
- misaligned  out  1  the registered instruction faulted.

Behaviour:
- **Accept rule:** an instruction is accepted when in_valid=1 and stall=0. While stall=1, all outputs hold their values and the RAM is not written.
- **Byte offset:** off = addr[log2(BUS_DATA_WIDTH/8)-1:0].
- **Word index:** the next DEPTH_LOG2 address bits. Address bits above these are ignored, so accesses wrap modulo the RAM size.
- **Alignment:**
  - An access is aligned when off is a multiple of the access size in bytes.
  - An access with an illegal accessSize is treated as misaligned.
- **Memory op:** op = accepted & !inMemOrReg & (memRead | memWrite).
  - If memRead and memWrite are both 1, memWrite is ignored and the op is a load.
- **Aligned store:** writes only the addressed byte lanes. writeData[8*size-1:0] goes to bytes off..off+size-1; all other bytes of the word are unchanged. The write takes effect at the accepting edge.
- **Misaligned op:**
  - No RAM write.
  - readData = 0.
  - misaligned = 1 in the output slot.
  - outWriteRegister passes through unchanged; the writeback stage suppresses it.
- **Aligned load, 1-cycle latency:** readData at the edge after acceptance = addressed bytes shifted to bit 0, then sign- or zero-extended per loadUnsigned.
  - Double loads (BUS_DATA_WIDTH = 64) are never extended.
  - Word loads on a 32-bit bus are never extended.
- **Back-to-back:** a load accepted the cycle after a store to the same word returns the new data. Store and load never coexist in one cycle.
- **ALU op** (inMemOrReg=1): outAluData <= addressOrAluData. memRead/memWrite are ignored and misaligned = 0.
- **Registered outputs on acceptance:**
  - out_valid=1.
  - outWriteRegister and outMemOrReg take their inputs.
  - readData and outAluData take new values only when the instruction is a load or an ALU op respectively; otherwise they hold.
- **Bubble:** when in_valid=0 and stall=0, out_valid <= 0, misaligned <= 0, and other outputs hold.
- **Reset:** all outputs are 0 on the edge where reset=1. RAM contents are not cleared.
  - Reset dominates stall and any in-flight instruction.
  - An instruction presented on a reset cycle does not write the RAM.
- No combinational path from any input to any output.

Test Plan:
1. **Sized store/load:**
   - Store double 0x1122334455667788 to address 0x10.
   - Then load byte at 0x13, signed -> readData 0x0000000000000055 one cycle after acceptance.
   - Then load half at 0x16, signed -> 0x0000000000001122.
2. **Sign/zero extension:**
   - Store byte 0xF0 to 0x20.
   - Load byte signed -> 0xFFFFFFFFFFFFFFF0.
   - Load byte unsigned -> 0x00000000000000F0.
   - Neighbouring bytes 0x21..0x27 are unchanged after the store.
3. **Misalignment:**
   - Word store to 0x22 -> misaligned=1, out_valid=1, RAM word at 0x20 unchanged (verify by double load).
   - Half load at 0x21 -> misaligned=1, readData 0.
4. **Stall and bubble:**
   - Hold stall=1 for 3 cycles with a store presented -> outputs frozen, no RAM write.
   - On release the store commits exactly once.
   - in_valid=0 -> out_valid=0 next cycle.
5. **Wrap and reset:**
   - With DEPTH_LOG2=4, store at 0x80 then load at 0x00 -> same data.
   - Assert reset mid-stream with a store presented -> all outputs 0 and the store is not committed.
   - Earlier RAM contents are still readable after reset.
6. **ALU pass-through and parametrisation:**
   - inMemOrReg=1, addressOrAluData=0xDEAD, memWrite=1 -> outAluData=0xDEAD and RAM untouched.
   - With BUS_DATA_WIDTH=32, accessSize=3 is flagged misaligned.
